// File: rtl/fft_ctrl.sv
// Radix-2 in-place FFT address/sequence controller: bit-reversed load, per-stage butterfly issue, drain, done.
// Optional FFT_CTRL_ABORT_EN macro adds an 'abort' input that returns the block to IDLE on the next edge.
module fft_ctrl #(
    parameter int no_point   = 8,
    parameter int log2_point = 3,
    parameter int bf_lat     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FFT_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  load_we,
    output logic [log2_point-1:0] load_addr,
    output logic                  bf_en,
    output logic [log2_point-1:0] rd_addr_a,
    output logic [log2_point-1:0] rd_addr_b,
    output logic [log2_point-2:0] tw_idx,
    output logic                  wr_en,
    output logic [log2_point-1:0] wr_addr_a,
    output logic [log2_point-1:0] wr_addr_b,
    output logic [log2_point-1:0] stage,
    output logic                  busy,
    output logic                  done
);

    if ((no_point != (1 << log2_point)) || (log2_point < 2) || (log2_point > 10) ||
        (bf_lat < 1) || (bf_lat > 8)) begin : g_param_err
        $error("fft_ctrl: illegal no_point/log2_point/bf_lat combination");
    end

    localparam int DW = $clog2(bf_lat + 1);
    localparam logic [log2_point-1:0] CNT_LAST = log2_point'(no_point - 1);
    localparam logic [log2_point-2:0] K_LAST   = (log2_point-1)'(no_point / 2 - 1);
    localparam logic [log2_point-1:0] STG_LAST = log2_point'(log2_point - 1);
    localparam logic [DW-1:0]         D_LAST   = DW'(bf_lat - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
    state_t state_q, state_nx;

    logic [log2_point-1:0] cnt_q;
    logic [log2_point-2:0] k_q;
    logic [log2_point-1:0] stage_q;
    logic [DW-1:0]         dcnt_q;
    logic                  abort_req;

`ifdef FFT_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (in_valid && cnt_q == CNT_LAST) state_nx = COMPUTE;
            COMPUTE: if (k_q == K_LAST) state_nx = DRAIN;
            DRAIN:   if (dcnt_q == D_LAST) state_nx = (stage_q == STG_LAST) ? DONE : COMPUTE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_req) state_nx = IDLE;
    end

    // Counters wrap naturally at their last value, so LOAD->COMPUTE and COMPUTE->DRAIN leave them at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            k_q     <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
        end else if (abort_req || state_q == IDLE || state_q == DONE) begin
            cnt_q   <= '0;
            k_q     <= '0;
            stage_q <= '0;
            dcnt_q  <= '0;
        end else begin
            case (state_q)
                LOAD:    if (in_valid) cnt_q <= cnt_q + 1'b1;
                COMPUTE: begin
                    k_q    <= k_q + 1'b1;
                    dcnt_q <= '0;
                end
                DRAIN: begin
                    dcnt_q <= dcnt_q + 1'b1;
                    if (state_nx == COMPUTE) stage_q <= stage_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [log2_point-1:0] rev, k_ext, half, pos, addr_a, tw_full;

    always_comb begin
        rev = '0;
        for (int i = 0; i < log2_point; i++) rev[i] = cnt_q[log2_point-1-i];
    end

    // Butterflies of one stage pair elements 'half' apart inside groups of 2*half.
    always_comb begin
        k_ext   = {1'b0, k_q};
        half    = log2_point'(1) << stage_q;
        pos     = k_ext & (half - 1'b1);
        addr_a  = ((k_ext >> stage_q) << (stage_q + 1'b1)) | pos;
        tw_full = pos << (STG_LAST - stage_q);
    end

    always_comb begin
        load_we   = 1'b0;
        load_addr = '0;
        bf_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        stage     = '0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        case (state_q)
            LOAD: begin
                load_we   = in_valid;
                load_addr = rev;
            end
            COMPUTE: begin
                bf_en     = 1'b1;
                rd_addr_a = addr_a;
                rd_addr_b = addr_a | half;
                tw_idx    = tw_full[log2_point-2:0];
                stage     = stage_q;
            end
            DRAIN: stage = stage_q;
            default: ;
        endcase
    end

    logic [bf_lat-1:0]                 en_pipe;
    logic [bf_lat-1:0][log2_point-1:0] a_pipe, b_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_pipe <= '0;
            a_pipe  <= '0;
            b_pipe  <= '0;
        end else if (abort_req) begin
            en_pipe <= '0;
            a_pipe  <= '0;
            b_pipe  <= '0;
        end else begin
            en_pipe[0] <= bf_en;
            a_pipe[0]  <= rd_addr_a;
            b_pipe[0]  <= rd_addr_b;
            for (int i = 1; i < bf_lat; i++) begin
                en_pipe[i] <= en_pipe[i-1];
                a_pipe[i]  <= a_pipe[i-1];
                b_pipe[i]  <= b_pipe[i-1];
            end
        end
    end

    assign wr_en     = en_pipe[bf_lat-1];
    assign wr_addr_a = a_pipe[bf_lat-1];
    assign wr_addr_b = b_pipe[bf_lat-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl (N=8, bf_lat=2): stimulus queues expected events, a negedge monitor retires them.
module tb_fft_ctrl;
    localparam int N = 8, L = 3, LAT = 2;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
`ifdef FFT_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    logic         load_we, bf_en, wr_en, busy, done;
    logic [L-1:0] load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
    logic [L-2:0] tw_idx;

    fft_ctrl #(.no_point(N), .log2_point(L), .bf_lat(LAT)) dut (
        .clk(clk), .rst(rst),
`ifdef FFT_CTRL_ABORT_EN
        .abort(abort),
`endif
        .start(start), .in_valid(in_valid),
        .load_we(load_we), .load_addr(load_addr), .bf_en(bf_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .stage(stage), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int b; int tw; int st; int cyc;} exp_t;
    exp_t q_bf[$], q_wr[$];
    int   q_load[$], q_done[$];
    int   total = 0, bad = 0, rel = 0;
    bit   armed = 1'b0;

    // Hand-derived tables for N=8: bit-reversed load order and stage 0/1/2 butterflies.
    int brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int pa[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int pb[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    // off = cycle of the first butterfly relative to the first accepted sample; each stage is 4 issues + 2 drain.
    task automatic push_expect(input int off);
        exp_t e;
        for (int i = 0; i < 8; i++) q_load.push_back(brv[i]);
        for (int i = 0; i < 12; i++) begin
            e.a = pa[i]; e.b = pb[i]; e.tw = tw[i]; e.st = i / 4;
            e.cyc = off + (i / 4) * 6 + (i % 4);
            q_bf.push_back(e);
            e.cyc = e.cyc + LAT;
            q_wr.push_back(e);
        end
        q_done.push_back(off + 18);
    endtask

    task automatic flush();
        q_bf.delete(); q_wr.delete(); q_load.delete(); q_done.delete();
        armed = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   x;
        if (!rst) armed = 1'b0;
        else begin
            if (load_we && !armed) begin armed = 1'b1; rel = 0; end
            else if (armed) rel++;
            if (load_we) begin
                total++;
                if (q_load.size() == 0) begin
                    bad++; $display("FAIL load_unexpected got addr=%0d", load_addr);
                end else begin
                    x = q_load.pop_front();
                    if (load_addr !== L'(x)) begin
                        bad++; $display("FAIL load_addr got=%0d want=%0d", load_addr, x);
                    end
                end
            end
            if (bf_en) begin
                total++;
                if (q_bf.size() == 0) begin
                    bad++; $display("FAIL bf_unexpected got a=%0d b=%0d", rd_addr_a, rd_addr_b);
                end else begin
                    e = q_bf.pop_front();
                    if (rd_addr_a !== L'(e.a) || rd_addr_b !== L'(e.b) || tw_idx !== (L-1)'(e.tw) ||
                        stage !== L'(e.st) || rel != e.cyc) begin
                        bad++;
                        $display("FAIL bf got a=%0d b=%0d tw=%0d st=%0d cyc=%0d want a=%0d b=%0d tw=%0d st=%0d cyc=%0d",
                                 rd_addr_a, rd_addr_b, tw_idx, stage, rel, e.a, e.b, e.tw, e.st, e.cyc);
                    end
                end
            end
            if (wr_en) begin
                total++;
                if (q_wr.size() == 0) begin
                    bad++; $display("FAIL wr_unexpected got a=%0d b=%0d", wr_addr_a, wr_addr_b);
                end else begin
                    e = q_wr.pop_front();
                    if (wr_addr_a !== L'(e.a) || wr_addr_b !== L'(e.b) || rel != e.cyc) begin
                        bad++;
                        $display("FAIL wr got a=%0d b=%0d cyc=%0d want a=%0d b=%0d cyc=%0d",
                                 wr_addr_a, wr_addr_b, rel, e.a, e.b, e.cyc);
                    end
                end
            end
            if (done) begin
                total++;
                if (q_done.size() == 0) begin
                    bad++; $display("FAIL done_unexpected at cyc=%0d", rel);
                end else begin
                    x = q_done.pop_front();
                    if (rel != x) begin
                        bad++; $display("FAIL done_cycle got=%0d want=%0d", rel, x);
                    end
                end
                armed = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++; $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {7'b0, load_we, load_addr, bf_en, rd_addr_a, rd_addr_b, tw_idx,
                 wr_en, wr_addr_a, wr_addr_b, stage, busy, done}, 32'h0);
    endtask

    task automatic start_and_load(input bit gap, input bit busy_start);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            if (gap && i < 7) begin
                start = busy_start;
                @(posedge clk); #1 start = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (q_done.size() != 0 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        total++;
        if (q_done.size() != 0) begin
            bad++; $display("FAIL %s_timeout got no done after %0d cycles", nm, n);
            flush();
        end
        chk({nm, "_busy_after"}, {31'b0, busy}, 32'h0);
        chk({nm, "_done_after"}, {31'b0, done}, 32'h0);
        repeat (3) @(posedge clk);
        #1 chk({nm, "_leftover"}, q_bf.size() + q_wr.size() + q_load.size(), 0);
    endtask

    task automatic run_xfer(input string nm, input bit gap);
        push_expect(gap ? 15 : 8);
        start_and_load(gap, gap);
        if (gap) begin
            // in_valid and start while computing must both be ignored
            in_valid = 1'b1; start = 1'b1;
            repeat (4) @(posedge clk);
            #1 in_valid = 1'b0; start = 1'b0;
        end
        wait_done(nm);
    endtask

    initial begin
        int n;
        #3 check_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_zero("idle_no_start");

        run_xfer("cont", 1'b0);
        run_xfer("gapped", 1'b1);

        // Asynchronous reset in the middle of stage 1
        push_expect(8);
        start_and_load(1'b0, 1'b0);
        n = 0;
        while (!(stage == 3'd1 && bf_en) && n < 40) begin
            @(posedge clk); #1 n++;
        end
        chk("reach_stage1", {31'b0, (stage == 3'd1 && bf_en)}, 32'h1);
        #2 rst = 1'b0;
        flush();
        #1 check_zero("rst_mid_xfer");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_zero("idle_after_rst");
        run_xfer("after_rst", 1'b0);

`ifdef FFT_CTRL_ABORT_EN
        push_expect(8);
        start_and_load(1'b0, 1'b0);
        n = 0;
        while (!(busy && !bf_en && stage == 3'd0) && n < 40) begin
            @(posedge clk); #1 n++;
        end
        chk("reach_drain", {31'b0, (busy && !bf_en && stage == 3'd0)}, 32'h1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        flush();
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_wr_en", {31'b0, wr_en}, 32'h0);
        repeat (6) @(posedge clk);
        #1 check_zero("abort_quiet");
        run_xfer("after_abort", 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
